// File: rtl/types_pkg.sv
// ----------------------------------------------------------------------------
// types_pkg: shared widths, FU result records and the CDB broadcast record.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package types_pkg;

    localparam int ROB_TAG_W = 5;
    localparam int PREG_W    = 7;
    localparam int XLEN      = 32;
    localparam int NUM_SRC   = 3;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_MEM = 2'd1,
        SRC_BR  = 2'd2
    } cdb_src_e;

    typedef struct packed {
        logic [PREG_W-1:0]    pd;
        logic [XLEN-1:0]      data;
        logic [ROB_TAG_W-1:0] rob_tag;
    } fu_result_t;

    typedef fu_result_t alu_data;
    typedef fu_result_t mem_data;
    typedef fu_result_t b_data;

    typedef struct packed {
        logic                 valid;
        logic [PREG_W-1:0]    pd;
        logic [XLEN-1:0]      data;
        logic [ROB_TAG_W-1:0] rob_tag;
        logic                 we;
        cdb_src_e             src;
    } cdb_data;

    // Distance from the ROB head; smaller is older.
    function automatic logic [ROB_TAG_W-1:0] rob_age(input logic [ROB_TAG_W-1:0] tag,
                                                    input logic [ROB_TAG_W-1:0] head);
        return tag - head;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cdb_fu_buffer.sv
// ----------------------------------------------------------------------------
// cdb_fu_buffer: per-FU result slots with oldest-first select and flush squash.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cdb_fu_buffer
    import types_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 done,
    input  fu_result_t           in_data,
    input  logic [ROB_TAG_W-1:0] rob_head,
    input  logic                 flush_valid,
    input  logic [ROB_TAG_W-1:0] flush_tag,
    input  logic                 deq,
    output logic                 ready,
    output logic                 cand_valid,
    output fu_result_t           cand
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0]     slot_valid;
    fu_result_t           slots [DEPTH];
    logic [DEPTH-1:0]     kill;
    logic [DEPTH-1:0]     enq_sel;
    logic [DEPTH-1:0]     deq_sel;
    logic [IDX_W-1:0]     free_idx;
    logic [IDX_W-1:0]     cand_idx;
    logic [ROB_TAG_W-1:0] best_age;
    logic [ROB_TAG_W-1:0] flush_age;
    logic                 found_free;
    logic                 in_young;
    logic                 enq;

    always_comb begin
        flush_age  = rob_age(flush_tag, rob_head);
        ready      = ~&slot_valid;
        free_idx   = '0;
        found_free = 1'b0;
        cand_valid = 1'b0;
        cand_idx   = '0;
        best_age   = '1;
        for (int i = 0; i < DEPTH; i++) begin
            if (!slot_valid[i] && !found_free) begin
                free_idx   = IDX_W'(i);
                found_free = 1'b1;
            end
            // Strict compare keeps the lower slot on an age tie.
            if (slot_valid[i] && (!cand_valid || rob_age(slots[i].rob_tag, rob_head) < best_age)) begin
                cand_valid = 1'b1;
                cand_idx   = IDX_W'(i);
                best_age   = rob_age(slots[i].rob_tag, rob_head);
            end
        end
        cand     = slots[cand_idx];
        in_young = flush_valid && (rob_age(in_data.rob_tag, rob_head) > flush_age);
        enq      = done && ready && !in_young;
        for (int i = 0; i < DEPTH; i++) begin
            kill[i]    = flush_valid && (rob_age(slots[i].rob_tag, rob_head) > flush_age);
            enq_sel[i] = enq && (free_idx == IDX_W'(i));
            deq_sel[i] = deq && (cand_idx == IDX_W'(i));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_valid <= '0;
        end else begin
            slot_valid <= (slot_valid & ~kill & ~deq_sel) | enq_sel;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (enq_sel[i]) begin
                slots[i] <= in_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// ----------------------------------------------------------------------------
// cdb_arbiter: round-robin CDB arbitration over ALU/MEM/BR result buffers.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cdb_arbiter
    import types_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  alu_data              alu_in,
    input  logic                 fu_alu_done,
    input  mem_data              mem_in,
    input  logic                 fu_mem_done,
    input  b_data                b_in,
    input  logic                 fu_b_done,
    output logic                 alu_ready,
    output logic                 mem_ready,
    output logic                 b_ready,
    input  logic [ROB_TAG_W-1:0] rob_head,
    input  logic                 flush_valid,
    input  logic [ROB_TAG_W-1:0] flush_tag,
    output cdb_data              cdb_out
);

    logic [NUM_SRC-1:0] done_v;
    logic [NUM_SRC-1:0] ready_v;
    logic [NUM_SRC-1:0] cand_valid_v;
    logic [NUM_SRC-1:0] deq_v;
    fu_result_t         in_v   [NUM_SRC];
    fu_result_t         cand_v [NUM_SRC];
    logic [1:0]         rr_ptr;
    logic [1:0]         win_src;
    logic               win_found;
    logic               grant;
    fu_result_t         win_entry;

    function automatic logic [1:0] next_src(input logic [1:0] s);
        return (s == 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

    assign in_v[0] = alu_in;
    assign in_v[1] = mem_in;
    assign in_v[2] = b_in;
    assign done_v  = {fu_b_done, fu_mem_done, fu_alu_done};

    generate
        for (genvar g = 0; g < NUM_SRC; g++) begin : g_buf
            cdb_fu_buffer #(
                .DEPTH(DEPTH)
            ) u_buf (
                .clk         (clk),
                .reset_n     (reset_n),
                .done        (done_v[g]),
                .in_data     (in_v[g]),
                .rob_head    (rob_head),
                .flush_valid (flush_valid),
                .flush_tag   (flush_tag),
                .deq         (deq_v[g]),
                .ready       (ready_v[g]),
                .cand_valid  (cand_valid_v[g]),
                .cand        (cand_v[g])
            );
        end
    endgenerate

    assign alu_ready = ready_v[0];
    assign mem_ready = ready_v[1];
    assign b_ready   = ready_v[2];

    // A winner younger than the flushing branch is suppressed, not replaced.
    always_comb begin
        logic [1:0] idx;
        idx       = rr_ptr;
        win_found = 1'b0;
        win_src   = rr_ptr;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!win_found && cand_valid_v[idx]) begin
                win_found = 1'b1;
                win_src   = idx;
            end
            idx = next_src(idx);
        end
        win_entry = cand_v[win_src];
        grant     = win_found &&
                    !(flush_valid &&
                      (rob_age(win_entry.rob_tag, rob_head) > rob_age(flush_tag, rob_head)));
        deq_v     = '0;
        if (grant) begin
            deq_v[win_src] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cdb_out <= '0;
            rr_ptr  <= SRC_ALU;
        end else begin
            cdb_out.valid <= grant;
            if (grant) begin
                cdb_out.pd      <= win_entry.pd;
                cdb_out.data    <= win_entry.data;
                cdb_out.rob_tag <= win_entry.rob_tag;
                cdb_out.we      <= (win_entry.pd != '0);
                cdb_out.src     <= cdb_src_e'(win_src);
                rr_ptr          <= next_src(win_src);
            end
        end
    end

endmodule

`default_nettype wire
